component_counter: RTL and testbench



---
 rtl/component_counter_pkg.sv | 19 +
 rtl/hypercube_spread.sv | 16 +
 rtl/component_counter.sv | 103 ++++++++++
 tb/tb_component_counter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/component_counter_pkg.sv
// Shared types and helpers for counting connected components on the 7-cube.
package component_counter_pkg;

  localparam int NODE_COUNT = 128;
  localparam int DIM        = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    GROW = 2'd2,
    EMIT = 2'd3
  } state_t;

  // Isolates the lowest set bit: m & -m.
  function automatic logic [NODE_COUNT-1:0] lowest_one_hot(input logic [NODE_COUNT-1:0] m);
    return m & (~m + {{(NODE_COUNT-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/hypercube_spread.sv
// One flood step on the 7-cube: each output node is set if it or any neighbour is set.
module hypercube_spread
  import component_counter_pkg::*;
(
  input  logic [NODE_COUNT-1:0] maskIn,
  output logic [NODE_COUNT-1:0] maskOut
);

  for (genvar i = 0; i < NODE_COUNT; i++) begin : g_node
    assign maskOut[i] = maskIn[i]
                      | maskIn[i ^ 1]  | maskIn[i ^ 2]  | maskIn[i ^ 4]
                      | maskIn[i ^ 8]  | maskIn[i ^ 16] | maskIn[i ^ 32]
                      | maskIn[i ^ 64];
  end

endmodule

// File: rtl/component_counter.sv
// Counts connected components of a 128-node hypercube subgraph by repeated flood fill.
// Optional macro COMPONENT_COUNTER_FAST_SINGLETON_EN retires isolated seeds directly in SEED.
module component_counter
  import component_counter_pkg::*;
#(
  parameter int COUNT_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   graphInValid,
  output logic                   graphInReady,
  input  logic [NODE_COUNT-1:0]  graphIn,
  output logic                   resultValid,
  input  logic                   resultReady,
  output logic [COUNT_WIDTH-1:0] connectCount,
  output logic                   busy
);

  // Handshakes: a transfer happens on any clk edge where valid and ready are both high;
  // the producer holds data stable while valid is high and ready is low.

  state_t                  state;
  logic [NODE_COUNT-1:0]   remaining;
  logic [NODE_COUNT-1:0]   explored;
  logic [COUNT_WIDTH-1:0]  count;
  logic [COUNT_WIDTH-1:0]  resultCount;

  logic [NODE_COUNT-1:0]   seedHot;
  logic [NODE_COUNT-1:0]   spreadIn;
  logic [NODE_COUNT-1:0]   spreadOut;
  logic [NODE_COUNT-1:0]   growNext;

  assign seedHot  = lowest_one_hot(remaining);
  // One spreader serves both the seed neighbour test in SEED and the flood in GROW.
  assign spreadIn = (state == SEED) ? seedHot : explored;

  hypercube_spread uSpread (
    .maskIn  (spreadIn),
    .maskOut (spreadOut)
  );

  assign growNext = spreadOut & remaining;

`ifdef COMPONENT_COUNTER_FAST_SINGLETON_EN
  logic seedIsolated;
  assign seedIsolated = (growNext == seedHot);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      explored    <= '0;
      count       <= '0;
      resultCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (graphInValid) begin
            remaining <= graphIn;
            count     <= '0;
            state     <= SEED;
          end
        end
        SEED: begin
          if (remaining == '0) begin
            resultCount <= count;
            state       <= EMIT;
          end
`ifdef COMPONENT_COUNTER_FAST_SINGLETON_EN
          else if (seedIsolated) begin
            remaining <= remaining & ~seedHot;
            count     <= count + COUNT_WIDTH'(1);
          end
`endif
          else begin
            explored <= seedHot;
            state    <= GROW;
          end
        end
        GROW: begin
          if (growNext != explored) begin
            explored <= growNext;
          end else begin
            remaining <= remaining & ~explored;
            count     <= count + COUNT_WIDTH'(1);
            state     <= SEED;
          end
        end
        EMIT: begin
          if (resultReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign graphInReady = (state == IDLE);
  assign busy         = (state != IDLE);
  assign resultValid  = (state == EMIT);
  assign connectCount = resultCount;

endmodule

// File: tb/tb_component_counter.sv
// Directed bench for component_counter: counts, latencies, backpressure and mid-run reset.
module tb_component_counter;

  localparam int LIMIT = 600;

`ifdef COMPONENT_COUNTER_FAST_SINGLETON_EN
  localparam int LAT_SINGLE = 2;
  localparam int LAT_TWO_ISO = 3;
  localparam int LAT_PARITY = 65;
`else
  localparam int LAT_SINGLE = 3;
  localparam int LAT_TWO_ISO = 5;
  localparam int LAT_PARITY = 129;
`endif
  localparam int LAT_EMPTY = 1;
  localparam int LAT_CHAIN = 5;
  localparam int LAT_FULL  = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         graphInValid;
  logic         graphInReady;
  logic [127:0] graphIn;
  logic         resultValid;
  logic         resultReady;
  logic [6:0]   connectCount;
  logic         busy;

  int checks = 0;
  int errors = 0;

  component_counter dut (
    .clk          (clk),
    .rst          (rst),
    .graphInValid (graphInValid),
    .graphInReady (graphInReady),
    .graphIn      (graphIn),
    .resultValid  (resultValid),
    .resultReady  (resultReady),
    .connectCount (connectCount),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Drivers: called at posedge+1, return at posedge+1.
  task automatic start_graph(input logic [127:0] g);
    graphInValid = 1'b1;
    graphIn      = g;
    @(posedge clk); #1;
    graphInValid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!resultValid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_result();
    resultReady = 1'b1;
    @(posedge clk); #1;
    resultReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; graphInValid = 1'b0; graphIn = '0; resultReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (graphInReady !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", graphInReady); end
    checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resultValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (connectCount !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", connectCount); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    int lat;
    resultReady = 1'b1;
    start_graph(128'h0);
    wait_result(lat);
    checks++; if (lat != LAT_EMPTY) begin errors++; $display("FAIL empty_latency got=%0d exp=%0d", lat, LAT_EMPTY); end
    checks++; if (connectCount !== 7'd0) begin errors++; $display("FAIL empty_count got=%0d exp=0", connectCount); end
    @(posedge clk); #1;
    checks++; if (graphInReady !== 1'b1) begin errors++; $display("FAIL empty_ready_back got=%b exp=1", graphInReady); end
    checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL empty_valid_drop got=%b exp=0", resultValid); end
    resultReady = 1'b0;
  endtask

  task automatic test_single();
    int lat;
    start_graph(128'h1);
    wait_result(lat);
    checks++; if (lat != LAT_SINGLE) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT_SINGLE); end
    checks++; if (connectCount !== 7'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", connectCount); end
    finish_result();
  endtask

  task automatic test_small();
    int lat;
    start_graph(128'h0B);
    wait_result(lat);
    checks++; if (lat != LAT_CHAIN) begin errors++; $display("FAIL chain_latency got=%0d exp=%0d", lat, LAT_CHAIN); end
    checks++; if (connectCount !== 7'd1) begin errors++; $display("FAIL chain_count got=%0d exp=1", connectCount); end
    finish_result();
    start_graph(128'h09);
    wait_result(lat);
    checks++; if (lat != LAT_TWO_ISO) begin errors++; $display("FAIL two_iso_latency got=%0d exp=%0d", lat, LAT_TWO_ISO); end
    checks++; if (connectCount !== 7'd2) begin errors++; $display("FAIL two_iso_count got=%0d exp=2", connectCount); end
    finish_result();
  endtask

  task automatic test_dense();
    int lat;
    start_graph({128{1'b1}});
    wait_result(lat);
    checks++; if (lat != LAT_FULL) begin errors++; $display("FAIL full_latency got=%0d exp=%0d", lat, LAT_FULL); end
    checks++; if (connectCount !== 7'd1) begin errors++; $display("FAIL full_count got=%0d exp=1", connectCount); end
    finish_result();
    start_graph(128'h9669_6996_6996_9669_6996_9669_9669_6996);
    wait_result(lat);
    checks++; if (lat != LAT_PARITY) begin errors++; $display("FAIL parity_latency got=%0d exp=%0d", lat, LAT_PARITY); end
    checks++; if (connectCount !== 7'd64) begin errors++; $display("FAIL parity_count got=%0d exp=64", connectCount); end
    finish_result();
  endtask

  task automatic test_backpressure();
    int lat;
    start_graph(128'h09);
    wait_result(lat);
    checks++; if (lat != LAT_TWO_ISO) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT_TWO_ISO); end
    graphInValid = 1'b1;
    graphIn      = 128'h1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (resultValid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold cyc=%0d got=%b exp=1", c, resultValid); end
      checks++; if (connectCount !== 7'd2) begin errors++; $display("FAIL bp_count_hold cyc=%0d got=%0d exp=2", c, connectCount); end
      checks++; if (graphInReady !== 1'b0) begin errors++; $display("FAIL bp_ready_low cyc=%0d got=%b exp=0", c, graphInReady); end
    end
    graphInValid = 1'b0;
    finish_result();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
    checks++; if (graphInReady !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got=%b exp=1", graphInReady); end
    checks++; if (connectCount !== 7'd2) begin errors++; $display("FAIL bp_idle_count_hold got=%0d exp=2", connectCount); end
  endtask

  task automatic test_mid_reset();
    int lat;
    start_graph({128{1'b1}});
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (graphInReady !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", graphInReady); end
    checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", resultValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    start_graph(128'h1);
    wait_result(lat);
    checks++; if (lat != LAT_SINGLE) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=%0d", lat, LAT_SINGLE); end
    checks++; if (connectCount !== 7'd1) begin errors++; $display("FAIL midrst_next_count got=%0d exp=1", connectCount); end
    finish_result();
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_small();
    test_dense();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
